costas_lock_ctrl: RTL and testbench

COSTAS_LOCK_CTRL -- requirements
Module: costas_lock_ctrl

---
 rtl/costas_pkg.sv | 16 +
 rtl/costas_lock_metric.sv | 61 ++++++
 rtl/costas_lock_ctrl.sv | 166 ++++++++++++++++
 tb/tb_costas_lock_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared state encoding and default loop-gain shifts for the Costas lock controller.
package costas_pkg;

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_TRACK  = 2'd2
  } costas_state_t;

  localparam logic [3:0] ACQ_SHIFT_DEF = 4'd2;
  localparam logic [3:0] TRK_SHIFT_DEF = 4'd6;

  // Wide enough for any practical lock/unlock window count.
  localparam int CNT_W = 8;

endpackage

// File: rtl/costas_lock_metric.sv
// Per-sample lock metric: saturating |I|,|Q|, BPSK/QPSK metric select, one register stage.
module costas_lock_metric #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_accept,
  input  logic                         i_clear,
  input  logic                         i_bpsk,
  input  logic signed [DATA_WIDTH-1:0] i_i,
  input  logic signed [DATA_WIDTH-1:0] i_q,
  output logic signed [DATA_WIDTH:0]   o_metric,
  output logic                         o_valid
);

  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // The most negative input has no positive twin, so it clamps to full scale.
  function automatic logic signed [DATA_WIDTH:0] sat_abs(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] a;
    if (x == S_MIN)
      a = S_MAX;
    else if (x[DATA_WIDTH-1])
      a = -x;
    else
      a = x;
    return {1'b0, a};
  endfunction

  logic signed [DATA_WIDTH:0] w_ai;
  logic signed [DATA_WIDTH:0] w_aq;
  logic signed [DATA_WIDTH:0] w_sum;
  logic signed [DATA_WIDTH:0] w_diff;
  logic signed [DATA_WIDTH:0] w_adiff;
  logic signed [DATA_WIDTH:0] w_qpsk;
  logic signed [DATA_WIDTH:0] w_sel;

  assign w_ai    = sat_abs(i_i);
  assign w_aq    = sat_abs(i_q);
  assign w_sum   = w_ai + w_aq;
  assign w_diff  = w_ai - w_aq;
  assign w_adiff = w_diff[DATA_WIDTH] ? -w_diff : w_diff;
  assign w_qpsk  = (w_sum >>> 1) - w_adiff;
  assign w_sel   = i_bpsk ? w_diff : w_qpsk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_metric <= '0;
      o_valid  <= 1'b0;
    end else if (i_clear) begin
      o_metric <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_accept;
      if (i_accept)
        o_metric <= w_sel;
    end
  end

endmodule

// File: rtl/costas_lock_ctrl.sv
// Costas loop lock detector: windowed metric accumulation and ACQ/SETTLE/TRACK gain sequencing.
//   state  | meaning
//   ACQ    | wide loop gain, counting consecutive good windows toward lock
//   SETTLE | narrow gain applied, next window discarded while the loop settles
//   TRACK  | locked, counting consecutive bad windows toward loss of lock
module costas_lock_ctrl
  import costas_pkg::*;
#(
  parameter int                DATA_WIDTH     = 16,
  parameter int                WIN_LOG2       = 10,
  parameter logic signed [31:0] LOCK_THRESH   = 32'sd4000000,
  parameter logic [3:0]        ACQ_SHIFT      = ACQ_SHIFT_DEF,
  parameter logic [3:0]        TRK_SHIFT      = TRK_SHIFT_DEF,
  parameter int                LOCK_WINDOWS   = 4,
  parameter int                UNLOCK_WINDOWS = 2
) (
  input  logic                                   clk_32M768,
  input  logic                                   rst_32M768,
  input  logic                                   enable,
  input  logic signed [DATA_WIDTH-1:0]           I_data,
  input  logic signed [DATA_WIDTH-1:0]           Q_data,
  input  logic                                   IQ_valid,
  input  logic                                   is_bpsk,
  input  logic                                   force_acq,
  output logic [3:0]                             FEEDBACK_SHIFT,
  output logic                                   locked,
  output logic [1:0]                             state,
  output logic signed [DATA_WIDTH+WIN_LOG2+1:0]  window_sum,
  output logic                                   window_done
);

  localparam int ACC_W = DATA_WIDTH + WIN_LOG2 + 2;
  localparam int CMP_W = (ACC_W > 32) ? ACC_W : 32;

  costas_state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]           r_good_cnt, w_good_nxt;
  logic [CNT_W-1:0]           r_bad_cnt, w_bad_nxt;
  logic [3:0]                 r_shift, w_shift_nxt;
  logic                       r_locked, w_locked_nxt;
  logic signed [ACC_W-1:0]    r_acc;
  logic [WIN_LOG2-1:0]        r_cnt;
  logic signed [ACC_W-1:0]    r_win_sum;
  logic                       r_win_done;
  logic                       r_prev_bpsk;

  logic                       w_restart;
  logic signed [DATA_WIDTH:0] w_metric;
  logic                       w_metric_vld;
  logic signed [ACC_W-1:0]    w_win_total;
  logic                       w_win_fire;
  logic signed [CMP_W-1:0]    w_total_ext;
  logic signed [CMP_W-1:0]    w_thresh_ext;
  logic                       w_good;

  assign w_restart = force_acq || (is_bpsk != r_prev_bpsk);

  costas_lock_metric #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_metric (
    .clk      (clk_32M768),
    .rst      (rst_32M768),
    .i_accept (enable && IQ_valid),
    .i_clear  (w_restart),
    .i_bpsk   (is_bpsk),
    .i_i      (I_data),
    .i_q      (Q_data),
    .o_metric (w_metric),
    .o_valid  (w_metric_vld)
  );

  assign w_win_total  = r_acc + ACC_W'(w_metric);
  assign w_win_fire   = w_metric_vld && (r_cnt == '1);
  assign w_total_ext  = CMP_W'(w_win_total);
  assign w_thresh_ext = CMP_W'(LOCK_THRESH);
  assign w_good       = w_total_ext > w_thresh_ext;

  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_state    <= ST_ACQ;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
      r_shift    <= ACQ_SHIFT;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_shift    <= w_shift_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    if (w_restart) begin
      w_state_nxt = ST_ACQ;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
    end else if (w_win_fire) begin
      unique case (r_state)
        ST_ACQ: begin
          if (!w_good)
            w_good_nxt = '0;
          else if (int'(r_good_cnt) + 1 >= LOCK_WINDOWS)
            w_state_nxt = ST_SETTLE;
          else
            w_good_nxt = r_good_cnt + CNT_W'(1);
        end
        ST_SETTLE: w_state_nxt = ST_TRACK;
        ST_TRACK: begin
          if (w_good)
            w_bad_nxt = '0;
          else if (int'(r_bad_cnt) + 1 >= UNLOCK_WINDOWS)
            w_state_nxt = ST_ACQ;
          else
            w_bad_nxt = r_bad_cnt + CNT_W'(1);
        end
        default: w_state_nxt = ST_ACQ;
      endcase
      if (w_state_nxt != r_state) begin
        w_good_nxt = '0;
        w_bad_nxt  = '0;
      end
    end
  end

  // Outputs are decoded from the next state so they register on the transition edge.
  always_comb begin
    w_shift_nxt  = (w_state_nxt == ST_ACQ) ? ACQ_SHIFT : TRK_SHIFT;
    w_locked_nxt = (w_state_nxt == ST_TRACK);
  end

  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_win_sum   <= '0;
      r_win_done  <= 1'b0;
      r_prev_bpsk <= 1'b0;
    end else begin
      r_prev_bpsk <= is_bpsk;
      r_win_done  <= 1'b0;
      if (w_restart) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_win_fire) begin
        r_win_sum  <= w_win_total;
        r_win_done <= 1'b1;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else if (w_metric_vld) begin
        r_acc <= w_win_total;
        r_cnt <= r_cnt + WIN_LOG2'(1);
      end
    end
  end

  assign FEEDBACK_SHIFT = r_shift;
  assign locked         = r_locked;
  assign state          = r_state;
  assign window_sum     = r_win_sum;
  assign window_done    = r_win_done;

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Self-checking bench for costas_lock_ctrl with a 16-sample window and toggling sample enable.
module tb_costas_lock_ctrl;

  localparam int DW  = 16;
  localparam int WL  = 4;
  localparam int NW  = 1 << WL;

  logic                    clk;
  logic                    rst;
  logic                    enable;
  logic signed [DW-1:0]    I_data;
  logic signed [DW-1:0]    Q_data;
  logic                    IQ_valid;
  logic                    is_bpsk;
  logic                    force_acq;
  logic [3:0]              FEEDBACK_SHIFT;
  logic                    locked;
  logic [1:0]              state;
  logic signed [DW+WL+1:0] window_sum;
  logic                    window_done;

  costas_lock_ctrl #(
    .DATA_WIDTH     (DW),
    .WIN_LOG2       (WL),
    .LOCK_THRESH    (32'sd16000),
    .LOCK_WINDOWS   (2),
    .UNLOCK_WINDOWS (2)
  ) dut (
    .clk_32M768     (clk),
    .rst_32M768     (rst),
    .enable         (enable),
    .I_data         (I_data),
    .Q_data         (Q_data),
    .IQ_valid       (IQ_valid),
    .is_bpsk        (is_bpsk),
    .force_acq      (force_acq),
    .FEEDBACK_SHIFT (FEEDBACK_SHIFT),
    .locked         (locked),
    .state          (state),
    .window_sum     (window_sum),
    .window_done    (window_done)
  );

  typedef struct {
    int sum;
    int st;
    int sh;
    int lk;
  } exp_t;

  typedef struct {
    logic bpsk;
    int   i;
    int   q;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  int   n_applied = 0;
  int   n_mis     = 0;
  int   n_done    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk);
      #1 enable = ~enable;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    n_applied++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && window_done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_applied++;
        n_mis++;
        $display("FAIL unexpected_window: got window_sum=%0d, required no window", window_sum);
      end else begin
        e = exp_q.pop_front();
        chk("window_sum", longint'(window_sum), e.sum);
        chk("state", state, e.st);
        chk("feedback_shift", FEEDBACK_SHIFT, e.sh);
        chk("locked", locked, e.lk);
      end
    end
  end

  task automatic send_sample(input int i, input int q);
    @(negedge clk);
    while (!enable) @(negedge clk);
    I_data   = 16'(i);
    Q_data   = 16'(q);
    IQ_valid = 1'b1;
    @(posedge clk);
    #1 IQ_valid = 1'b0;
  endtask

  task automatic send_window(input int i, input int q, input exp_t e);
    exp_q.push_back(e);
    for (int k = 0; k < NW; k++) send_sample(i, q);
  endtask

  task automatic settle_wait();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_restart();
    settle_wait();
    @(negedge clk);
    force_acq = 1'b1;
    @(negedge clk);
    force_acq = 1'b0;
    @(negedge clk);
  endtask

  task automatic reach_track();
    send_window(2000, 0, '{32000, 0, 2, 0});
    send_window(2000, 0, '{32000, 1, 6, 0});
    send_window(2000, 0, '{32000, 2, 6, 1});
    settle_wait();
    chk("reach_track_state", state, 2);
  endtask

  vec_t vecs[17];
  int   done_base;

  initial begin
    vecs[0]  = '{1'b1,   2000,      0, '{  32000, 0, 2, 0}};
    vecs[1]  = '{1'b1,   2000,      0, '{  32000, 1, 6, 0}};
    vecs[2]  = '{1'b1,   2000,      0, '{  32000, 2, 6, 1}};
    vecs[3]  = '{1'b1,      0,   2000, '{ -32000, 2, 6, 1}};
    vecs[4]  = '{1'b1,      0,   2000, '{ -32000, 0, 2, 0}};
    vecs[5]  = '{1'b1, -32768,      0, '{ 524272, 0, 2, 0}};
    vecs[6]  = '{1'b1,      0, -32768, '{-524272, 0, 2, 0}};
    vecs[7]  = '{1'b1,   2000,      0, '{  32000, 0, 2, 0}};
    vecs[8]  = '{1'b0,   1000,   1000, '{  16000, 0, 2, 0}};
    vecs[9]  = '{1'b0,   1000,   1000, '{  16000, 0, 2, 0}};
    vecs[10] = '{1'b0,   1100,   1100, '{  17600, 0, 2, 0}};
    vecs[11] = '{1'b0,   1100,   1100, '{  17600, 1, 6, 0}};
    vecs[12] = '{1'b0,   1100,  -1100, '{  17600, 2, 6, 1}};
    vecs[13] = '{1'b0,   3000,      0, '{ -24000, 2, 6, 1}};
    vecs[14] = '{1'b0,   1000,   1000, '{  16000, 0, 2, 0}};
    vecs[15] = '{1'b0,   3001,      0, '{ -24016, 0, 2, 0}};
    vecs[16] = '{1'b0, -32768, -32768, '{ 524272, 0, 2, 0}};

    rst       = 1'b1;
    I_data    = '0;
    Q_data    = '0;
    IQ_valid  = 1'b0;
    is_bpsk   = 1'b1;
    force_acq = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_shift", FEEDBACK_SHIFT, 2);
    chk("reset_locked", locked, 0);
    chk("reset_window_sum", longint'(window_sum), 0);
    chk("reset_window_done", window_done, 0);
    rst = 1'b0;
    settle_wait();

    for (int v = 0; v < 17; v++) begin
      if (is_bpsk != vecs[v].bpsk) begin
        settle_wait();
        @(negedge clk);
        is_bpsk = vecs[v].bpsk;
        repeat (2) @(negedge clk);
      end
      send_window(vecs[v].i, vecs[v].q, vecs[v].e);
    end
    settle_wait();
    @(negedge clk);
    is_bpsk = 1'b1;
    repeat (2) @(negedge clk);

    // force_acq in TRACK discards the partial window
    do_restart();
    reach_track();
    for (int k = 0; k < 5; k++) send_sample(0, 2000);
    @(negedge clk);
    force_acq = 1'b1;
    @(negedge clk);
    force_acq = 1'b0;
    chk("force_state", state, 0);
    chk("force_locked", locked, 0);
    chk("force_shift", FEEDBACK_SHIFT, 2);
    send_window(2000, 0, '{32000, 0, 2, 0});

    // mode change in TRACK discards the partial window
    do_restart();
    reach_track();
    for (int k = 0; k < 5; k++) send_sample(0, 2000);
    @(negedge clk);
    is_bpsk = 1'b0;
    @(negedge clk);
    chk("mode_state", state, 0);
    chk("mode_locked", locked, 0);
    chk("mode_shift", FEEDBACK_SHIFT, 2);
    send_window(1100, 1100, '{17600, 0, 2, 0});
    settle_wait();
    @(negedge clk);
    is_bpsk = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-window in TRACK
    do_restart();
    reach_track();
    for (int k = 0; k < 5; k++) send_sample(2000, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_shift", FEEDBACK_SHIFT, 2);
    chk("arst_locked", locked, 0);
    chk("arst_window_sum", longint'(window_sum), 0);
    chk("arst_window_done", window_done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    done_base = n_done;
    for (int k = 0; k < NW - 1; k++) send_sample(2000, 0);
    settle_wait();
    chk("arst_no_early_done", n_done - done_base, 0);
    exp_q.push_back('{32000, 0, 2, 0});
    send_sample(2000, 0);
    settle_wait();
    chk("arst_full_window_done", n_done - done_base, 1);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_mis);
    $finish;
  end

endmodule
